// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one iterative shift-add unsigned multiplier shared by N
// requesters under round-robin arbitration. One product is in flight at a time.
// Results return on a shared response bus tagged with the owner's index.
// Optional build macro: MUL_EARLY_EXIT_EN lets BUSY finish as soon as the
// remaining multiplier bits are all zero. Products are identical either way.
module mul_share_arbiter #(
    parameter int SIZE = 8,
    parameter int N    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    input  logic [N*SIZE-1:0]     req_num1,
    input  logic [N*SIZE-1:0]     req_num2,
    output logic [N-1:0]          req_ready,
    output logic                  resp_valid,
    output logic [$clog2(N)-1:0]  resp_id,
    output logic [2*SIZE-1:0]     resp_result,
    output logic                  busy
);

    localparam int IDW   = $clog2(N);
    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, next_state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      owner;
    logic [IDW-1:0]      winner;
    logic [IDW-1:0]      scan_idx;
    logic                found;
    logic [N-1:0]        grant;
    logic                accept;
    logic                last_iter;
    logic [2*SIZE-1:0]   num1_reg;
    logic [SIZE-1:0]     num2_reg;
    logic [2*SIZE-1:0]   sum;
    logic [2*SIZE-1:0]   sum_next;
    logic [CNT_W-1:0]    cnt;
    logic [SIZE-1:0]     sel_num1;
    logic [SIZE-1:0]     sel_num2;

    // Pointer plus offset, wrapped into 0..N-1 without relying on N being a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        logic [IDW:0] s;
        s = {1'b0, p} + (IDW+1)'(k);
        if (s >= (IDW+1)'(N)) begin
            s = s - (IDW+1)'(N);
        end
        return s[IDW-1:0];
    endfunction

    // Round-robin scan: first asserted request starting at the pointer, wrapping around.
    always_comb begin
        grant    = '0;
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = wrap_add(ptr, k);
            if (!found && req_valid[scan_idx]) begin
                found           = 1'b1;
                winner          = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // Route the winner's operands using the one-hot grant so only constant slices are needed.
    always_comb begin
        sel_num1 = '0;
        sel_num2 = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_num1 = req_num1[i*SIZE +: SIZE];
                sel_num2 = req_num2[i*SIZE +: SIZE];
            end
        end
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign sum_next = sum + (num2_reg[0] ? num1_reg : '0);

`ifdef MUL_EARLY_EXIT_EN
    // Finish once the multiplier has no set bits left after this step's shift.
    assign last_iter = (num2_reg[SIZE-1:1] == '0) || (cnt == LAST_CNT);
`else
    // Fixed latency: always run all SIZE iterations.
    assign last_iter = (cnt == LAST_CNT);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant logic; grants are offered only when the engine is free and not in reset.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (!rst) begin
                    req_ready = grant;
                end
                accept     = |(req_valid & req_ready);
                next_state = accept ? BUSY : IDLE;
            end
            BUSY: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture operands on acceptance, iterate in BUSY, publish the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            owner       <= '0;
            num1_reg    <= '0;
            num2_reg    <= '0;
            sum         <= '0;
            cnt         <= '0;
            resp_id     <= '0;
            resp_result <= '0;
        end else if (accept) begin
            num1_reg <= {{SIZE{1'b0}}, sel_num1};
            num2_reg <= sel_num2;
            sum      <= '0;
            cnt      <= '0;
            owner    <= winner;
            ptr      <= (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
        end else if (state == BUSY) begin
            sum      <= sum_next;
            num1_reg <= num1_reg << 1;
            num2_reg <= num2_reg >> 1;
            cnt      <= cnt + 1'b1;
            if (last_iter) begin
                resp_result <= sum_next;
                resp_id     <= owner;
            end
        end
    end

    assign resp_valid = (state == DONE) && !rst;
    assign busy       = (state == BUSY) && !rst;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scoreboard bench for mul_share_arbiter (SIZE=8, N=4).
// Expected products, owners and latencies are queued at grant time and popped on resp_valid.
module tb_mul_share_arbiter;

    localparam int SIZE = 8;
    localparam int N    = 4;

    typedef struct {
        int          id;
        logic [15:0] result;
        int          latency;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N*SIZE-1:0]    req_num1;
    logic [N*SIZE-1:0]    req_num2;
    logic [N-1:0]         req_ready;
    logic                 resp_valid;
    logic [1:0]           resp_id;
    logic [2*SIZE-1:0]    resp_result;
    logic                 busy;

    exp_t sb[$];
    int   compared;
    int   mismatched;
    int   stray;

    mul_share_arbiter #(.SIZE(SIZE), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_num1    (req_num1),
        .req_num2    (req_num2),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded waits stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int expLat(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) h = i + 1;
        end
        return (h == 0) ? 1 : h;
`else
        return 8;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b);
        req_num1[id*SIZE +: SIZE] = a;
        req_num2[id*SIZE +: SIZE] = b;
        req_valid[id]             = 1'b1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Check that requester id is granted, record its expected result, then take the acceptance edge.
    task automatic grantStep(input int id, input bit doPush);
        exp_t e;
        logic [7:0] a;
        logic [7:0] b;
        #1;
        checkOutput($sformatf("ready_grant%0d", id), 32'(req_ready), 32'(1 << id));
        a = req_num1[id*SIZE +: SIZE];
        b = req_num2[id*SIZE +: SIZE];
        e.id      = id;
        e.result  = 16'(a) * 16'(b);
        e.latency = expLat(b);
        if (doPush) sb.push_back(e);
        @(posedge clk);
    endtask

    // Called just after an acceptance edge; returns at the negedge of the DONE cycle.
    task automatic waitResponse();
        exp_t e;
        int edges;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (resp_valid) break;
        end
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("latency", 32'(edges), 32'(e.latency));
            checkOutput("resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("resp_id", 32'(resp_id), 32'(e.id));
            checkOutput("resp_result", 32'(resp_result), 32'(e.result));
            checkOutput("busy_in_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_num1   = '0;
        req_num2   = '0;

        // Reset state
        resetDut();
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
        checkOutput("rst_resp_result", 32'(resp_result), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready_idle", 32'(req_ready), 32'd0);

        // Single request 3*5
        $display("[TB] single request");
        applyStimulus(0, 8'd3, 8'd5);
        grantStep(0, 1'b1);
        #1 req_valid = '0;
        #1 checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("ready_in_busy", 32'(req_ready), 32'd0);
        waitResponse();
        @(posedge clk);
        @(negedge clk);
        checkOutput("pulse_one_cycle", 32'(resp_valid), 32'd0);
        checkOutput("result_hold", 32'(resp_result), 32'h000F);

        // All four requesting from reset: back-to-back round robin
        $display("[TB] all four requesting");
        for (int i = 0; i < N; i++) applyStimulus(i, 8'(i + 1), 8'd10);
        resetDut();
        for (int i = 0; i < N; i++) begin
            grantStep(i, 1'b1);
            waitResponse();
        end
        #1 checkOutput("ready_wrap_all", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Requesters 0 and 2 held: alternate grants, 1 and 3 idle
        $display("[TB] requesters 0 and 2");
        resetDut();
        applyStimulus(0, 8'd7, 8'd9);
        applyStimulus(2, 8'hFF, 8'hFF);
        for (int r = 0; r < 2; r++) begin
            grantStep(0, 1'b1);
            waitResponse();
            grantStep(2, 1'b1);
            waitResponse();
        end
        #1 checkOutput("ready_after_02", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Zero multiplier, then early-exit candidates, rotating through requesters 1..3
        $display("[TB] boundary operands");
        applyStimulus(1, 8'hAB, 8'h00);
        grantStep(1, 1'b1);
        #1 req_valid = '0;
        waitResponse();
        applyStimulus(2, 8'hAB, 8'h01);
        grantStep(2, 1'b1);
        #1 req_valid = '0;
        waitResponse();
        applyStimulus(3, 8'hAB, 8'h80);
        grantStep(3, 1'b1);
        #1 req_valid = '0;
        waitResponse();

        // Reset in the middle of an operation
        $display("[TB] reset during busy");
        @(negedge clk);
        applyStimulus(3, 8'h12, 8'hFF);
        grantStep(3, 1'b0);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1001;
        #1;
        checkOutput("ready_abort_rst", 32'(req_ready), 32'd0);
        checkOutput("busy_abort_rst", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        checkOutput("abort_resp_result", 32'(resp_result), 32'd0);
        checkOutput("abort_resp_id", 32'(resp_id), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        checkOutput("abort_no_resp", 32'(stray), 32'd0);
        applyStimulus(0, 8'd2, 8'd3);
        req_valid = 4'b1001;
        grantStep(0, 1'b1);
        #1 req_valid = '0;
        waitResponse();

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
